// File: rtl/sram_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter_if
// Purpose  : Bundles the two requester handshakes and the dual-port SRAM
//            macro pins used by sram_arbiter.
// Ports    : rN_* - requester N (0/1) request/command/ack/read-data
//            sram_*_a - read-only port A pins, sram_*_b - write-only port B
// Modports : slave  - the arbiter side
//            master - the requester/macro side (testbench, top level glue)
// Revision : 1.0 - initial release
// ============================================================================
interface sram_arbiter_if #(
    parameter int ADDR_WD = 9,
    parameter int DATA_WD = 32
);
    localparam int c_MASK_WD = DATA_WD / 8;

    logic                 r0_req;
    logic                 r0_we;
    logic [ADDR_WD-1:0]   r0_addr;
    logic [DATA_WD-1:0]   r0_wdata;
    logic [c_MASK_WD-1:0] r0_mask;
    logic                 r0_ack;
    logic [DATA_WD-1:0]   r0_rdata;

    logic                 r1_req;
    logic                 r1_we;
    logic [ADDR_WD-1:0]   r1_addr;
    logic [DATA_WD-1:0]   r1_wdata;
    logic [c_MASK_WD-1:0] r1_mask;
    logic                 r1_ack;
    logic [DATA_WD-1:0]   r1_rdata;

    logic                 sram_csb_a;
    logic [ADDR_WD-1:0]   sram_addr_a;
    logic [DATA_WD-1:0]   sram_dout_a;
    logic                 sram_csb_b;
    logic                 sram_web_b;
    logic [c_MASK_WD-1:0] sram_mask_b;
    logic [ADDR_WD-1:0]   sram_addr_b;
    logic [DATA_WD-1:0]   sram_din_b;

    modport slave (
        input  r0_req, r0_we, r0_addr, r0_wdata, r0_mask,
        input  r1_req, r1_we, r1_addr, r1_wdata, r1_mask,
        output r0_ack, r0_rdata, r1_ack, r1_rdata,
        output sram_csb_a, sram_addr_a,
        input  sram_dout_a,
        output sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b
    );

    modport master (
        output r0_req, r0_we, r0_addr, r0_wdata, r0_mask,
        output r1_req, r1_we, r1_addr, r1_wdata, r1_mask,
        input  r0_ack, r0_rdata, r1_ack, r1_rdata,
        input  sram_csb_a, sram_addr_a,
        output sram_dout_a,
        input  sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b
    );
endinterface
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Two-requester arbiter/sequencer for a dual-port SRAM macro with a
//            read-only port A and a write-only port B. Each port has its own
//            FSM and arbitration pointer, so a read and a write from different
//            requesters can be in flight together. A read to the address that
//            port B is writing (or is granting a write to) is held off until
//            the write strobe has completed.
// Ports    : wb_clk_i - clock, rising edge
//            wb_rst_i - synchronous active-high reset
//            bus      - sram_arbiter_if.slave (requesters + SRAM macro pins)
// Params   : ADDR_WD  - word address width
//            DATA_WD  - data width (byte mask is DATA_WD/8)
//            ARB_MODE - 0 round-robin per port, 1 fixed priority (r0 wins)
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_WD  = 9,
    parameter int DATA_WD  = 32,
    parameter int ARB_MODE = 0
) (
    input  wire logic     wb_clk_i,
    input  wire logic     wb_rst_i,
    sram_arbiter_if.slave bus
);
    localparam int c_MASK_WD = DATA_WD / 8;

    // Port B (write) states
    localparam logic [1:0] c_B_IDLE = 2'd0;
    localparam logic [1:0] c_B_WR   = 2'd1;
    localparam logic [1:0] c_B_ACK  = 2'd2;

    // Port A (read) states
    localparam logic [1:0] c_A_IDLE = 2'd0;
    localparam logic [1:0] c_A_RD   = 2'd1;
    localparam logic [1:0] c_A_CAP  = 2'd2;
    localparam logic [1:0] c_A_ACK  = 2'd3;

    // ------------------------------------------------------------------------
    // Registered state and outputs
    // ------------------------------------------------------------------------
    logic [1:0]           r_b_state;
    logic                 r_b_owner;
    logic                 r_b_pref;     // requester preferred on the next B tie
    logic [1:0]           r_a_state;
    logic                 r_a_owner;
    logic                 r_a_pref;     // requester preferred on the next A tie

    logic                 r_csb_a;
    logic [ADDR_WD-1:0]   r_addr_a;
    logic                 r_csb_b;
    logic                 r_web_b;
    logic [c_MASK_WD-1:0] r_mask_b;
    logic [ADDR_WD-1:0]   r_addr_b;
    logic [DATA_WD-1:0]   r_din_b;
    logic [1:0]           r_ack;
    logic [DATA_WD-1:0]   r_rdata [2];

    // ------------------------------------------------------------------------
    // Requester inputs gathered into indexable form
    // ------------------------------------------------------------------------
    logic [1:0]           w_req;
    logic [1:0]           w_we;
    logic [ADDR_WD-1:0]   w_addr  [2];
    logic [DATA_WD-1:0]   w_wdata [2];
    logic [c_MASK_WD-1:0] w_mask  [2];

    assign w_req      = {bus.r1_req, bus.r0_req};
    assign w_we       = {bus.r1_we,  bus.r0_we};
    assign w_addr[0]  = bus.r0_addr;
    assign w_addr[1]  = bus.r1_addr;
    assign w_wdata[0] = bus.r0_wdata;
    assign w_wdata[1] = bus.r1_wdata;
    assign w_mask[0]  = bus.r0_mask;
    assign w_mask[1]  = bus.r1_mask;

    // ------------------------------------------------------------------------
    // Eligibility
    // ------------------------------------------------------------------------
    logic [1:0]         w_busy;
    logic [1:0]         w_elig_b;
    logic [1:0]         w_elig_a;
    logic [1:0]         w_collide;
    logic               w_gnt_b_vld;
    logic               w_gnt_b_id;
    logic [ADDR_WD-1:0] w_gnt_b_addr;
    logic               w_gnt_a_vld;
    logic               w_gnt_a_id;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_req
            // A requester holds at most one transaction; the ACK state still
            // counts as owned so the ack cycle can never re-grant.
            assign w_busy[gi] = ((r_a_state != c_A_IDLE) && (r_a_owner == 1'(gi))) ||
                                ((r_b_state != c_B_IDLE) && (r_b_owner == 1'(gi)));

            assign w_elig_b[gi] = w_req[gi] & w_we[gi] & ~w_busy[gi] & ~r_ack[gi];

            // Read must wait behind a same-address write that is strobing now
            // or being granted on this edge.
            assign w_collide[gi] = ((r_b_state == c_B_WR) && (r_addr_b == w_addr[gi])) ||
                                   (w_gnt_b_vld && (w_gnt_b_addr == w_addr[gi]));

            assign w_elig_a[gi] = w_req[gi] & ~w_we[gi] & ~w_busy[gi] & ~r_ack[gi] &
                                  ~w_collide[gi];
        end
    endgenerate

    always_comb begin
        w_gnt_b_vld = 1'b0;
        w_gnt_b_id  = 1'b0;
        if (r_b_state == c_B_IDLE) begin
            if (w_elig_b == 2'b11) begin
                w_gnt_b_vld = 1'b1;
                w_gnt_b_id  = (ARB_MODE == 1) ? 1'b0 : r_b_pref;
            end else if (w_elig_b[0]) begin
                w_gnt_b_vld = 1'b1;
                w_gnt_b_id  = 1'b0;
            end else if (w_elig_b[1]) begin
                w_gnt_b_vld = 1'b1;
                w_gnt_b_id  = 1'b1;
            end
        end
    end

    assign w_gnt_b_addr = w_addr[w_gnt_b_id];

    always_comb begin
        w_gnt_a_vld = 1'b0;
        w_gnt_a_id  = 1'b0;
        if (r_a_state == c_A_IDLE) begin
            if (w_elig_a == 2'b11) begin
                w_gnt_a_vld = 1'b1;
                w_gnt_a_id  = (ARB_MODE == 1) ? 1'b0 : r_a_pref;
            end else if (w_elig_a[0]) begin
                w_gnt_a_vld = 1'b1;
                w_gnt_a_id  = 1'b0;
            end else if (w_elig_a[1]) begin
                w_gnt_a_vld = 1'b1;
                w_gnt_a_id  = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Port FSMs and registered outputs
    // ------------------------------------------------------------------------
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_b_state  <= c_B_IDLE;
            r_b_owner  <= 1'b0;
            r_b_pref   <= 1'b0;
            r_a_state  <= c_A_IDLE;
            r_a_owner  <= 1'b0;
            r_a_pref   <= 1'b0;
            r_csb_a    <= 1'b1;
            r_addr_a   <= '0;
            r_csb_b    <= 1'b1;
            r_web_b    <= 1'b1;
            r_mask_b   <= '0;
            r_addr_b   <= '0;
            r_din_b    <= '0;
            r_ack      <= 2'b00;
            r_rdata[0] <= '0;
            r_rdata[1] <= '0;
        end else begin
            r_ack <= 2'b00;

            case (r_b_state)
                c_B_IDLE: begin
                    if (w_gnt_b_vld) begin
                        r_b_state <= c_B_WR;
                        r_b_owner <= w_gnt_b_id;
                        r_b_pref  <= ~w_gnt_b_id;
                        r_csb_b   <= 1'b0;
                        r_web_b   <= 1'b0;
                        r_addr_b  <= w_gnt_b_addr;
                        r_din_b   <= w_wdata[w_gnt_b_id];
                        r_mask_b  <= w_mask[w_gnt_b_id];
                    end
                end
                c_B_WR: begin
                    r_b_state        <= c_B_ACK;
                    r_csb_b          <= 1'b1;
                    r_web_b          <= 1'b1;
                    r_ack[r_b_owner] <= 1'b1;
                end
                c_B_ACK: r_b_state <= c_B_IDLE;
                default: r_b_state <= c_B_IDLE;
            endcase

            case (r_a_state)
                c_A_IDLE: begin
                    if (w_gnt_a_vld) begin
                        r_a_state <= c_A_RD;
                        r_a_owner <= w_gnt_a_id;
                        r_a_pref  <= ~w_gnt_a_id;
                        r_csb_a   <= 1'b0;
                        r_addr_a  <= w_addr[w_gnt_a_id];
                    end
                end
                c_A_RD: begin
                    r_a_state <= c_A_CAP;
                    r_csb_a   <= 1'b1;
                end
                c_A_CAP: begin
                    // Macro output is valid this cycle; capture and ack together.
                    r_a_state          <= c_A_ACK;
                    r_rdata[r_a_owner] <= bus.sram_dout_a;
                    r_ack[r_a_owner]   <= 1'b1;
                end
                c_A_ACK: r_a_state <= c_A_IDLE;
                default: r_a_state <= c_A_IDLE;
            endcase
        end
    end

    assign bus.sram_csb_a  = r_csb_a;
    assign bus.sram_addr_a = r_addr_a;
    assign bus.sram_csb_b  = r_csb_b;
    assign bus.sram_web_b  = r_web_b;
    assign bus.sram_mask_b = r_mask_b;
    assign bus.sram_addr_b = r_addr_b;
    assign bus.sram_din_b  = r_din_b;
    assign bus.r0_ack      = r_ack[0];
    assign bus.r1_ack      = r_ack[1];
    assign bus.r0_rdata    = r_rdata[0];
    assign bus.r1_rdata    = r_rdata[1];

endmodule
`default_nettype wire

// File: doc/sram_arbiter.md
# sram_arbiter

Two-requester arbiter and sequencer for the shared dual-port 512x32 SRAM macro. Port A is read-only and port B is write-only. The block serialises access per port between requester 0 (the Wishbone SRAM wrapper path) and requester 1 (a secondary on-chip master such as a UART/SPI DMA engine). It generates the active-low SRAM strobes with the correct macro timing, returns read data and one-cycle acknowledges, and prevents same-address read/write collisions.

## Interface
Parameters:
- ADDR_WD, 9: SRAM word address width.
- DATA_WD, 32: SRAM data width; byte mask width is DATA_WD/8.
- ARB_MODE, 0: 0 = round-robin per port; 1 = fixed priority, r0 always wins.

Ports:
- wb_clk_i  in  1  system clock; all logic on the rising edge.
- wb_rst_i  in  1  reset, synchronous, active-high.
- rN_req  in  1  request from requester N (N = 0, 1); held high until rN_ack.
- rN_we  in  1  1 = write (port B), 0 = read (port A); stable while req is high.
- rN_addr  in  ADDR_WD  word address; stable while req is high.
- rN_wdata  in  DATA_WD  write data; stable while req is high.
- rN_mask  in  DATA_WD/8  byte write enables; stable while req is high.
- rN_ack  out  1  one-cycle completion pulse.
- rN_rdata  out  DATA_WD  read data, valid in the rN_ack cycle of a read; held otherwise.
- sram_csb_a  out  1  port A chip select, active-low.
- sram_addr_a  out  ADDR_WD  port A address.
- sram_dout_a  in  DATA_WD  port A read data.
- sram_csb_b  out  1  port B chip select, active-low.
- sram_web_b  out  1  port B write enable, active-low.
- sram_mask_b  out  DATA_WD/8  port B byte mask.
- sram_addr_b  out  ADDR_WD  port B address.
- sram_din_b  out  DATA_WD  port B write data.

## Operation
- All outputs are registered.
- Reset values: sram_csb_a=1, sram_csb_b=1, sram_web_b=1, sram_mask_b=0, both addresses 0, sram_din_b=0, r0_ack=r1_ack=0, rN_rdata=0, both round-robin pointers pointing to r0.
- Port A and port B are independent and run concurrently; a read from one requester can overlap a write from the other.
- Port B FSM: IDLE -> WR -> ACK -> IDLE.
  - WR: sram_csb_b=0 and sram_web_b=0 for exactly one cycle, with the latched addr, mask and data.
  - ACK: rN_ack=1 to the owner.
- Port A FSM: IDLE -> RD -> CAP -> ACK -> IDLE.
  - RD: sram_csb_a=0 for one cycle.
  - CAP: sram_dout_a is registered into rN_rdata at the end of the CAP cycle.
  - ACK: rN_ack=1 to the owner.
- Grants are issued only from IDLE. On the grant edge the FSM latches owner, addr, wdata and mask.
- Eligibility: a requester is eligible for a port when all of the following hold:
  - req=1 and we matches the port;
  - it does not own an in-flight transaction on either port;
  - its ack is not asserted in that cycle.
- Round-robin (ARB_MODE=0): when both requesters are eligible, grant the one not granted last on that port. Each port keeps its own pointer, updated on every grant.
- Fixed priority (ARB_MODE=1): r0 wins every tie.
- Collision rule: a read is deferred while its addr equals the addr of a port B transaction in WR, or of a write being granted in the same cycle. The write goes first; the read is granted once port B leaves WR.
- Reset mid-transaction: both FSMs return to IDLE on the next edge, strobes are deasserted, and no ack is issued. Requesters must reissue.
- Unused SRAM outputs hold their last value while the strobes are high.

## Timing
- Write latency, from req sampled high at edge E0 while port B is idle:
  - cycle E0+1: csb_b=0, web_b=0;
  - cycle E0+2: ack.
  - Port B occupancy is 2 cycles plus 1 idle cycle before the next grant.
- Read latency, from req sampled at E0:
  - cycle E0+1: csb_a=0;
  - cycle E0+2: macro dout valid and captured;
  - cycle E0+3: ack with rdata.
- The requester must drop req, or change the transaction, in the cycle after the ack. The arbiter ignores req during the ack cycle, so there is no double-grant.
- Maximum throughput per port: one write every 3 cycles, one read every 4 cycles.
- Starvation bound in round-robin mode: a waiting requester is granted within one foreign transaction.

## Test plan
- Reset: hold wb_rst_i for 3 cycles during an r0 read in RD.
  - Required: csb_a=1 on the next edge, no r0_ack, and all outputs at their reset values.
- Single write then read:
  - r0 writes addr 0x1A4, data 0xDEADBEEF, mask 0xF. Required: csb_b/web_b low in exactly one cycle, r0_ack 2 cycles after req.
  - r0 then reads 0x1A4. Required: r0_ack 3 cycles after req with r0_rdata=0xDEADBEEF.
- Concurrent ports: r0 reads 0x010 while r1 writes 0x020 in the same cycle.
  - Required: csb_a and csb_b both low in the same cycle; r1_ack arrives one cycle before r0_ack.
- Round-robin fairness: both requesters issue continuous writes to distinct addresses.
  - Required: grants alternate r0, r1, r0, r1 starting with r0 after reset.
  - With ARB_MODE=1, r0 wins every tie.
- Collision: r1 writes 0x055 with data 0x12345678 while r0 reads 0x055 in the same cycle.
  - Required: the write strobe precedes the read strobe, and r0_rdata=0x12345678.
- Partial mask: write 0xFFFFFFFF to 0x003, then 0x00000000 with mask 0x5, then read 0x003.
  - Required: rdata=0xFF00FF00.
